// File: rtl/seg_score_reader.sv
// Reads three latched active-low seven-segment digits, converts them to a binary
// score over three cycles and tracks the highest legal score seen since reset.
module seg_score_reader #(
   parameter int SCORE_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [6:0]         seg2,
   input  logic [6:0]         seg1,
   input  logic [6:0]         seg0,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic [2:0]         o_dbg_state
);

   // Handshake: start is a request sampled only in IDLE; done is a one-cycle
   // strobe and error/score/high_score are valid while done is high.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_D2   = 3'd1,
      S_D1   = 3'd2,
      S_D0   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [6:0]           r_sh2;
   logic [6:0]           r_sh1;
   logic [6:0]           r_sh0;
   logic [SCORE_W-1:0]   r_acc;
   logic                 r_sticky;
   logic                 r_error;
   logic [SCORE_W-1:0]   r_score;
   logic [SCORE_W-1:0]   r_high;
   logic [6:0]           w_sel;
   logic [3:0]           w_digit;
   logic                 w_illegal;
   logic [SCORE_W-1:0]   w_acc_next;
   logic                 w_sticky_next;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_D2;
         S_D2:   begin busy = 1'b1; w_next = S_D1;   end
         S_D1:   begin busy = 1'b1; w_next = S_D0;   end
         S_D0:   begin busy = 1'b1; w_next = S_DONE; end
         S_DONE: begin done = 1'b1; w_next = S_IDLE; end
         default: w_next = S_IDLE;
      endcase
   end

   // The digit being folded in this cycle is chosen by the current state.
   always_comb begin
      w_sel = r_sh0;
      case (r_state)
         S_D2:    w_sel = r_sh2;
         S_D1:    w_sel = r_sh1;
         default: w_sel = r_sh0;
      endcase
   end

   always_comb begin
      w_digit   = 4'd0;
      w_illegal = 1'b0;
      case (w_sel)
         7'b1000000: w_digit = 4'd0;
         7'b1111001: w_digit = 4'd1;
         7'b0100100: w_digit = 4'd2;
         7'b0110000: w_digit = 4'd3;
         7'b0011001: w_digit = 4'd4;
         7'b0010010: w_digit = 4'd5;
         7'b0000010: w_digit = 4'd6;
         7'b1111000: w_digit = 4'd7;
         7'b0000000: w_digit = 4'd8;
         7'b0010000: w_digit = 4'd9;
         7'b1111111: w_digit = 4'd0;
         default:    w_illegal = 1'b1;
      endcase
   end

   // acc*10 as two shifts; acc never exceeds 99 before the last step, so 999 fits.
   assign w_acc_next    = (r_acc << 3) + (r_acc << 1) + {{(SCORE_W-4){1'b0}}, w_digit};
   assign w_sticky_next = r_sticky | w_illegal;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh2    <= '0;
         r_sh1    <= '0;
         r_sh0    <= '0;
         r_acc    <= '0;
         r_sticky <= 1'b0;
         r_error  <= 1'b0;
         r_score  <= '0;
         r_high   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sh2    <= seg2;
                  r_sh1    <= seg1;
                  r_sh0    <= seg0;
                  r_acc    <= '0;
                  r_sticky <= 1'b0;
               end
            end
            S_D2, S_D1: begin
               r_acc    <= w_acc_next;
               r_sticky <= w_sticky_next;
            end
            S_D0: begin
               r_acc    <= w_acc_next;
               r_sticky <= w_sticky_next;
               if (w_sticky_next) begin
                  r_error <= 1'b1;
               end else begin
                  r_error <= 1'b0;
                  r_score <= w_acc_next;
                  if (w_acc_next > r_high) r_high <= w_acc_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign error       = r_error;
   assign score       = r_score;
   assign high_score  = r_high;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_score_reader.sv
// Scoreboard bench for seg_score_reader: expected results are queued when a read
// is launched and compared when the done strobe appears.
module tb_seg_score_reader;

   localparam int SCORE_W = 10;
   localparam int EXP_W   = 2*SCORE_W + 1;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [6:0]         seg2;
   logic [6:0]         seg1;
   logic [6:0]         seg0;
   logic               busy;
   logic               done;
   logic               error;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] high_score;
   logic [2:0]         dbg_state;

   int checks = 0;
   int errors = 0;

   logic [EXP_W-1:0]   exp_q[$];
   logic [SCORE_W-1:0] m_score;
   logic [SCORE_W-1:0] m_high;

   logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] BAD   = 7'b0101010;

   seg_score_reader #(.SCORE_W(SCORE_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .seg2        (seg2),
      .seg1        (seg1),
      .seg0        (seg0),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .score       (score),
      .high_score  (high_score),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic void ref_decode(input logic [6:0] p, output int val, output bit ill);
      val = 0;
      ill = (p != BLANK);
      for (int d = 0; d < 10; d++) begin
         if (p == pat_tab[d]) begin
            val = d;
            ill = 1'b0;
         end
      end
   endfunction

   task automatic push_expect(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
      int v2, v1, v0, acc;
      bit i2, i1, i0;
      ref_decode(a, v2, i2);
      ref_decode(b, v1, i1);
      ref_decode(c, v0, i0);
      acc = v2*100 + v1*10 + v0;
      if (!(i2 || i1 || i0)) begin
         m_score = SCORE_W'(acc);
         if (SCORE_W'(acc) > m_high) m_high = SCORE_W'(acc);
      end
      exp_q.push_back({(i2 || i1 || i0), m_score, m_high});
   endtask

   // Launch one read and follow it for 8 cycles; optionally disturb the inputs
   // and pulse start while the read is in D1.
   task automatic run_read(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                           input bit disturb, input string name);
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at  = -1;
      logic [EXP_W-1:0] e;
      @(negedge clk);
      seg2 = a; seg1 = b; seg0 = c;
      start = 1'b1;
      push_expect(a, b, c);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (disturb && n == 2) begin
            start = 1'b1;
            seg2 = pat_tab[$urandom_range(0, 9)];
            seg1 = BAD;
            seg0 = pat_tab[$urandom_range(0, 9)];
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = n;
               e = exp_q.pop_front();
               checks++;
               if ({error, score, high_score} !== e) begin
                  errors++;
                  $display("FAIL %s result: got err=%0b score=%0d high=%0d, expected err=%0b score=%0d high=%0d",
                           name, error, score, high_score, e[EXP_W-1], e[EXP_W-2:SCORE_W], e[SCORE_W-1:0]);
               end
            end
         end
      end
      if (done_at < 0 && exp_q.size() > 0) e = exp_q.pop_front();
      checks++;
      if (done_at !== 4) begin
         errors++;
         $display("FAIL %s latency: done at cycle %0d, expected 4", name, done_at);
      end
      checks++;
      if (busy_cnt !== 3) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d, expected 3", name, busy_cnt);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt);
      end
      checks++;
      if (error !== e[EXP_W-1]) begin
         errors++;
         $display("FAIL %s error_hold: got %0b, expected %0b", name, error, e[EXP_W-1]);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({busy, done, error, score, high_score, dbg_state} !== '0) begin
         errors++;
         $display("FAIL %s zero_outputs: busy=%0b done=%0b err=%0b score=%0d high=%0d state=%0d, expected all 0",
                  name, busy, done, error, score, high_score, dbg_state);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0;
      seg2 = BLANK; seg1 = BLANK; seg0 = BLANK;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      m_score = '0; m_high = '0;
      @(negedge clk);
      check_all_zero("reset");
   endtask

   task automatic test_read_123();
      run_read(pat_tab[1], pat_tab[2], pat_tab[3], 1'b0, "read_123");
   endtask

   task automatic test_leading_blanks();
      run_read(BLANK, BLANK, pat_tab[4], 1'b0, "leading_blanks");
   endtask

   task automatic test_max();
      run_read(pat_tab[9], pat_tab[9], pat_tab[9], 1'b0, "max_999");
      run_read(pat_tab[0], pat_tab[5], pat_tab[0], 1'b0, "after_max_050");
      run_read(pat_tab[9], pat_tab[9], pat_tab[9], 1'b0, "equal_high");
   endtask

   task automatic test_illegal();
      run_read(pat_tab[1], BAD, pat_tab[3], 1'b0, "illegal_mid");
      run_read(pat_tab[4], pat_tab[5], pat_tab[6], 1'b0, "legal_clears");
      run_read(pat_tab[7], pat_tab[7], 7'b0110001, 1'b0, "illegal_ones");
   endtask

   task automatic test_back_to_back();
      run_read(pat_tab[2], pat_tab[7], pat_tab[1], 1'b1, "busy_disturb");
   endtask

   task automatic test_reset_mid_read();
      int done_cnt = 0;
      @(negedge clk);
      seg2 = pat_tab[8]; seg1 = pat_tab[8]; seg0 = pat_tab[8];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_score = '0; m_high = '0;
      check_all_zero("reset_mid_read");
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_read aborted_done: got %0d pulses, expected 0", done_cnt);
      end
      run_read(pat_tab[3], pat_tab[1], pat_tab[2], 1'b0, "after_reset");
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      seg2 = pat_tab[5]; seg1 = pat_tab[5]; seg0 = pat_tab[5];
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      m_score = '0; m_high = '0;
      check_all_zero("reset_priority");
   endtask

   task automatic test_random();
      logic [6:0] a, b, c;
      for (int r = 0; r < 6; r++) begin
         a = ($urandom_range(0, 3) == 0) ? BLANK : pat_tab[$urandom_range(0, 9)];
         b = pat_tab[$urandom_range(0, 9)];
         c = ($urandom_range(0, 5) == 0) ? BAD : pat_tab[$urandom_range(0, 9)];
         run_read(a, b, c, 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_read_123();
      test_leading_blanks();
      test_max();
      test_illegal();
      test_back_to_back();
      test_reset_mid_read();
      test_reset_priority();
      test_random();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_score_reader.md
SEG_SCORE_READER -- requirements
Module: seg_score_reader

Interface
REQ-001 Parameter: SCORE_W, default 10, width of the binary score outputs; SHALL be at least 10 so that 999 fits.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  request to read the three digit inputs; sampled only in IDLE.
REQ-005 seg2  input  7  hundreds digit, active-low seven-segment pattern {g,f,e,d,c,b,a}.
REQ-006 seg1  input  7  tens digit, same encoding.
REQ-007 seg0  input  7  ones digit, same encoding.
REQ-008 busy  output  1  high while digits are being decoded.
REQ-009 done  output  1  single-cycle completion strobe.
REQ-010 error  output  1  last read contained an illegal pattern; valid whenever done is high.
REQ-011 score  output  SCORE_W  binary value of the last legal read.
REQ-012 high_score  output  SCORE_W  maximum legal score read since reset.

Function
REQ-013 Legal patterns SHALL decode as follows: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
REQ-014 Blank pattern 1111111 SHALL decode as 0 (leading-blank support) and SHALL NOT be an error.
REQ-015 Any other pattern SHALL be illegal.
REQ-016 FSM states SHALL be IDLE, D2, D1, D0, DONE; reset SHALL force IDLE.
REQ-017 IDLE: when start=1 at edge k, the block SHALL latch seg2/seg1/seg0 into shadow registers, clear the accumulator and the sticky illegal flag, and go to D2.
REQ-018 Inputs SHALL be sampled only at edge k; later changes to seg* SHALL NOT affect the result.
REQ-019 D2 (edge k+1), D1 (edge k+2), D0 (edge k+3): the block SHALL set acc = acc*10 + decode(shadow digit), OR the digit's illegal flag into the sticky flag, and advance D2->D1->D0->DONE.
REQ-020 Accumulator SHALL be SCORE_W bits; the maximum value 999 SHALL produce no overflow, and illegal digits SHALL contribute 0.
REQ-021 busy SHALL be 1 exactly in states D2, D1 and D0, i.e. between edges k+1 and k+3 inclusive of the intervening cycles.
REQ-022 At edge k+3, if the sticky flag is clear: score <= final acc; high_score <= max(high_score, final acc); error <= 0.
REQ-023 At edge k+3, if the sticky flag is set: score and high_score SHALL hold their values; error <= 1.
REQ-024 done SHALL be 1 only in DONE, i.e. the cycle after edge k+3, giving a latency of 4 edges from start to done.
REQ-025 DONE SHALL return to IDLE at the next edge unconditionally.
REQ-026 start SHALL be ignored in D2, D1, D0 and DONE; no request is queued.
REQ-027 error SHALL hold its value until the next completion or reset.
REQ-028 When final acc equals high_score, high_score SHALL be unchanged.

Reset
REQ-029 Reset=1 at any edge, including mid-read, SHALL set state=IDLE, busy=0, done=0, error=0, score=0, high_score=0, shadows=0, acc=0 and the sticky flag=0, and SHALL abort any read in progress.
REQ-030 Reset SHALL take priority over start at the same edge.
REQ-031 An aborted read SHALL produce no done pulse.

Verification
REQ-032 Read 1/2/3: seg2=1111001, seg1=0100100, seg0=0110000, start pulse -> busy for 3 cycles, done one cycle later, score=123, high_score=123, error=0.
REQ-033 Leading blanks: seg2=1111111, seg1=1111111, seg0=0011001 -> score=4, error=0, high_score stays 123.
REQ-034 Maximum value: read 9/9/9 -> score=999, high_score=999; then read 0/5/0 -> score=50, high_score=999.
REQ-035 Illegal digit: seg1=0101010 on a read -> done with error=1, score and high_score unchanged; the next legal read clears error.
REQ-036 Input change and start while busy: change seg* and pulse start during D1 -> result uses the latched values, exactly one done pulse, and no second read.
REQ-037 Reset during D1 -> no done pulse; all outputs 0 on the next cycle; a fresh start then completes normally.
